sync_fifo_cfg: RTL and testbench

//   Single-clock FIFO for same-domain buffering. Register-array storage with

---
 rtl/sync_fifo_cfg.sv | 87 ++++++++
 tb/tb_sync_fifo_cfg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_cfg.sv
// Single-clock register-array FIFO; read latency 1 cycle (FWFT=0) or 0 (FWFT=1).
// Backpressure: writes dropped while full, reads ignored while empty, both flagged sticky.
module sync_fifo_cfg #(
  parameter int DEEPWID = 3,
  parameter int BITWID  = 5,
  parameter int FWFT    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [BITWID-1:0]  wr_data,
  input  logic               rd_en,
  output logic [BITWID-1:0]  rd_data,
  output logic               rd_data_vld,
  input  logic [DEEPWID:0]   cfg_almost_full,
  input  logic [DEEPWID:0]   cfg_almost_empty,
  input  logic               err_clr,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [DEEPWID:0]   fifo_num,
  output logic               overflow,
  output logic               underflow
);

  localparam int DEPTH = 2**DEEPWID;
  localparam logic [DEEPWID:0] DEPTH_N = (DEEPWID+1)'(DEPTH);

  logic [BITWID-1:0]  mem [DEPTH];
  logic [DEEPWID-1:0] wr_ptr;
  logic [DEEPWID-1:0] rd_ptr;
  logic               wr_acc;
  logic               rd_acc;

  assign full         = (fifo_num == DEPTH_N);
  assign empty        = (fifo_num == '0);
  assign almost_full  = (fifo_num >= cfg_almost_full);
  assign almost_empty = (fifo_num <= cfg_almost_empty);

  // A read in the same cycle does not make room for a write while full.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_num  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + DEEPWID'(1);
      if (rd_acc) rd_ptr <= rd_ptr + DEEPWID'(1);
      case ({wr_acc, rd_acc})
        2'b10:   fifo_num <= fifo_num + (DEEPWID+1)'(1);
        2'b01:   fifo_num <= fifo_num - (DEEPWID+1)'(1);
        default: fifo_num <= fifo_num;
      endcase
      // Set has priority over a simultaneous clear.
      if (wr_en & full)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (rd_en & empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data     = mem[rd_ptr];
    assign rd_data_vld = ~empty;
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data     <= '0;
        rd_data_vld <= 1'b0;
      end else begin
        rd_data_vld <= rd_acc;
        if (rd_acc) rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Directed bench: registered-read and FWFT instances share one stimulus stream.
module tb_sync_fifo_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, err_clr;
  logic [4:0] wr_data;
  logic [3:0] cfg_af, cfg_ae;

  logic [4:0] rd_data0, rd_data1;
  logic       vld0, vld1, full0, full1, empty0, empty1;
  logic       af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
  logic [3:0] num0, num1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_cfg #(.DEEPWID(3), .BITWID(5), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_data_vld(vld0), .cfg_almost_full(cfg_af),
    .cfg_almost_empty(cfg_ae), .err_clr(err_clr), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .fifo_num(num0), .overflow(ovf0),
    .underflow(udf0)
  );

  sync_fifo_cfg #(.DEEPWID(3), .BITWID(5), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_data_vld(vld1), .cfg_almost_full(cfg_af),
    .cfg_almost_empty(cfg_ae), .err_clr(err_clr), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .fifo_num(num1), .overflow(ovf1),
    .underflow(udf1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); wr_data = '0; cfg_af = 4'd8; cfg_ae = 4'd0;
    step(); step();
    n_cmp++; if (num0 !== 4'd0) begin n_err++; $display("FAIL reset_num got=%0d exp=0", num0); end
    n_cmp++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin n_err++; $display("FAIL reset_flags got=%b exp=1010", {empty0, full0, ae0, af0}); end
    n_cmp++; if ({ovf0, udf0, vld0, vld1} !== 4'b0000) begin n_err++; $display("FAIL reset_err_vld got=%b exp=0000", {ovf0, udf0, vld0, vld1}); end
    cfg_af = 4'd0; #1;
    n_cmp++; if (af0 !== 1'b1) begin n_err++; $display("FAIL reset_af_cfg0 got=%b exp=1", af0); end
    cfg_af = 4'd8;
    rst_n = 1'b1;
    step();
    n_cmp++; if (empty1 !== 1'b1) begin n_err++; $display("FAIL post_reset_empty got=%b exp=1", empty1); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 5'(i + 1);
      step();
      n_cmp++; if (num0 !== 4'(i + 1)) begin n_err++; $display("FAIL fill_num got=%0d exp=%0d", num0, i + 1); end
    end
    idle();
    n_cmp++; if (full0 !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", full0); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rd_data1 !== 5'(i + 1)) begin n_err++; $display("FAIL fwft_head got=%h exp=%h", rd_data1, 5'(i + 1)); end
      rd_en = 1'b1;
      step();
      n_cmp++; if (vld0 !== 1'b1 || rd_data0 !== 5'(i + 1)) begin n_err++; $display("FAIL drain_data got=%b/%h exp=1/%h", vld0, rd_data0, 5'(i + 1)); end
      n_cmp++; if (num0 !== 4'(7 - i)) begin n_err++; $display("FAIL drain_num got=%0d exp=%0d", num0, 7 - i); end
    end
    idle();
    step();
    n_cmp++; if (vld0 !== 1'b0 || rd_data0 !== 5'h08) begin n_err++; $display("FAIL drain_hold got=%b/%h exp=0/08", vld0, rd_data0); end
    n_cmp++; if (empty0 !== 1'b1 || vld1 !== 1'b0) begin n_err++; $display("FAIL drain_empty got=%b/%b exp=1/0", empty0, vld1); end
  endtask

  task automatic test_overflow_underflow();
    logic [4:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 5'h11 + 5'(i);
      step();
    end
    wr_data = 5'h1F;
    step();
    n_cmp++; if (ovf0 !== 1'b1 || num0 !== 4'd8) begin n_err++; $display("FAIL ovf_set got=%b/%0d exp=1/8", ovf0, num0); end
    // read accepted while full, write still rejected
    rd_en = 1'b1; wr_data = 5'h1E;
    step();
    n_cmp++; if (num0 !== 4'd7 || rd_data0 !== 5'h11) begin n_err++; $display("FAIL full_rw got=%0d/%h exp=7/11", num0, rd_data0); end
    idle(); err_clr = 1'b1;
    step();
    n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b exp=0", ovf0); end
    idle();
    for (int i = 0; i < 7; i++) begin
      rd_en = 1'b1;
      step();
      exp_d = 5'h12 + 5'(i);
      n_cmp++; if (rd_data0 !== exp_d) begin n_err++; $display("FAIL ovf_drain got=%h exp=%h", rd_data0, exp_d); end
    end
    step();
    n_cmp++; if (udf0 !== 1'b1 || vld0 !== 1'b0) begin n_err++; $display("FAIL udf_set got=%b/%b exp=1/0", udf0, vld0); end
    err_clr = 1'b1;
    step();
    n_cmp++; if (udf0 !== 1'b1) begin n_err++; $display("FAIL udf_set_wins got=%b exp=1", udf0); end
    idle(); err_clr = 1'b1;
    step();
    n_cmp++; if (udf0 !== 1'b0 || num0 !== 4'd0) begin n_err++; $display("FAIL udf_clr got=%b/%0d exp=0/0", udf0, num0); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 5'(i + 1);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      exp_d = 5'(k + 1);
      n_cmp++; if (rd_data1 !== exp_d) begin n_err++; $display("FAIL b2b_fwft got=%h exp=%h", rd_data1, exp_d); end
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 5'(k + 5);
      step();
      n_cmp++; if (num0 !== 4'd4 || rd_data0 !== exp_d) begin n_err++; $display("FAIL b2b got=%0d/%h exp=4/%h", num0, rd_data0, exp_d); end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      rd_en = 1'b1;
      step();
      exp_d = 5'(k + 21);
      n_cmp++; if (rd_data0 !== exp_d) begin n_err++; $display("FAIL b2b_tail got=%h exp=%h", rd_data0, exp_d); end
    end
    idle();
  endtask

  task automatic test_thresholds();
    cfg_af = 4'd6; cfg_ae = 4'd2;
    for (int n = 0; n <= 8; n++) begin
      #1;
      n_cmp++; if (ae0 !== (n <= 2) || af0 !== (n >= 6)) begin n_err++; $display("FAIL thresh n=%0d got=%b%b exp=%b%b", n, ae0, af0, n <= 2, n >= 6); end
      if (n < 8) begin
        wr_en = 1'b1; wr_data = 5'(n);
        step();
        idle();
      end
    end
    cfg_ae = 4'd8; #1;
    n_cmp++; if (ae0 !== 1'b1) begin n_err++; $display("FAIL thresh_cfg_live got=%b exp=1", ae0); end
    cfg_ae = 4'd2;
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    idle();
    cfg_af = 4'd8; cfg_ae = 4'd0;
  endtask

  task automatic test_fwft();
    wr_en = 1'b1; wr_data = 5'h0A;
    step();
    idle();
    n_cmp++; if (vld1 !== 1'b1 || rd_data1 !== 5'h0A) begin n_err++; $display("FAIL fwft_show got=%b/%h exp=1/0a", vld1, rd_data1); end
    n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL reg_no_vld got=%b exp=0", vld0); end
    rd_en = 1'b1;
    step();
    idle();
    n_cmp++; if (empty1 !== 1'b1 || vld1 !== 1'b0) begin n_err++; $display("FAIL fwft_pop got=%b/%b exp=1/0", empty1, vld1); end
    n_cmp++; if (vld0 !== 1'b1 || rd_data0 !== 5'h0A) begin n_err++; $display("FAIL reg_pop got=%b/%h exp=1/0a", vld0, rd_data0); end
  endtask

  task automatic test_async_reset();
    rd_en = 1'b1;
    step();
    idle();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 5'h03 + 5'(i);
      step();
    end
    idle();
    n_cmp++; if (num0 !== 4'd5 || udf0 !== 1'b1) begin n_err++; $display("FAIL pre_rst got=%0d/%b exp=5/1", num0, udf0); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (num0 !== 4'd0 || empty0 !== 1'b1 || num1 !== 4'd0) begin n_err++; $display("FAIL async_rst got=%0d/%b exp=0/1", num0, empty0); end
    n_cmp++; if ({ovf0, udf0, udf1, vld1} !== 4'b0000) begin n_err++; $display("FAIL async_rst_err got=%b exp=0000", {ovf0, udf0, udf1, vld1}); end
    step();
    rst_n = 1'b1;
    wr_en = 1'b1; wr_data = 5'h15;
    step();
    idle();
    n_cmp++; if (rd_data1 !== 5'h15 || num0 !== 4'd1) begin n_err++; $display("FAIL post_rst_wr got=%h/%0d exp=15/1", rd_data1, num0); end
    rd_en = 1'b1;
    step();
    idle();
    n_cmp++; if (vld0 !== 1'b1 || rd_data0 !== 5'h15) begin n_err++; $display("FAIL post_rst_rd got=%b/%h exp=1/15", vld0, rd_data0); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_back_to_back();
    test_thresholds();
    test_fwft();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
